// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Multi-cycle instruction fetch/issue unit. It owns the PC and fetches one
// instruction at a time from instruction memory (req/ack). It presents the
// decoded fields to control/datapath (valid/ready). It then waits for the
// resolve strobe and loads the next PC from the Jump/JumpSel/Branch results.
// Each instruction takes at least three cycles:
//   FETCH (ack) -> HOLD (ready) -> EXEC (resolve) -> FETCH ...
//
// Ports
//   clk, reset       : clock and synchronous active-high reset
//   imem_req/addr    : fetch request; the request is held until imem_ack
//   imem_ack/data    : memory response; imem_data is valid with imem_ack
//   ir_valid/ready   : field handshake towards control/datapath
//   opcode..target   : fields sliced from the held instruction register
//   pc_plus4         : PC+4 of the held instruction (JAL link value)
//   resolve          : one-cycle strobe; the redirect inputs are valid with it
//   Jump, JumpSel, Branch, br_cond, reg_target : redirect inputs
//   misalign         : sticky flag for a JR to a non-word-aligned target
//   instret          : number of resolved instructions (wraps)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [25:0] target,
  output logic [31:0] pc_plus4,
  input  logic        resolve,
  input  logic        Jump,
  input  logic        JumpSel,
  input  logic        Branch,
  input  logic        br_cond,
  input  logic [31:0] reg_target,
  output logic        misalign,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {FETCH, HOLD, EXEC} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] next_pc;
  logic [31:0] br_offset;

  // Every field output is a direct slice of a register. No logic sits
  // between the flops and the pins.
  assign imem_addr = pc;
  assign opcode    = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign funct     = ir[5:0];
  assign imm16     = ir[15:0];
  assign target    = ir[25:0];

  assign br_offset = {{14{ir[15]}}, ir[15:0], 2'b00};

  // Redirect priority: JR, then J/JAL, then a taken branch, then fall-through.
  // When Jump and Branch are both set, the jump wins.
  always_comb begin
    // NOTE: the default assignment comes first, so every path drives next_pc
    // and no latch is inferred.
    next_pc = pc_plus4;
    if (Jump && JumpSel)
      next_pc = {reg_target[31:2], 2'b00};
    else if (Jump)
      next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
    else if (Branch && br_cond)
      next_pc = pc_plus4 + br_offset;
  end

  // NOTE: state is updated with non-blocking assignments only. Every register
  // then sees the pre-edge values of the others, which keeps simulation and
  // synthesis consistent.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      imem_req <= 1'b1;
      ir_valid <= 1'b0;
      pc_plus4 <= '0;
      misalign <= 1'b0;
      instret  <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          // The request is always up in FETCH. The extra imem_req term makes
          // a stray ack outside a request harmless.
          if (imem_req && imem_ack) begin
            ir       <= imem_data;
            pc_plus4 <= pc + 32'd4;
            imem_req <= 1'b0;
            ir_valid <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (resolve) begin
            pc       <= next_pc;
            instret  <= instret + 32'd1;
            imem_req <= 1'b1;
            state    <= FETCH;
            if (Jump && JumpSel && (reg_target[1:0] != 2'b00))
              misalign <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
